// File: rtl/ballot_collector.sv
// Vote collector: assembles N_VOTERS single-bit votes into a frame held until acked.
// Optional even-parity trailer bit when BALLOT_PARITY_EN is defined.
module ballot_collector #(
  parameter int N_VOTERS = 7,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vote_valid,
  input  logic                vote_bit,
  output logic                vote_ready,
  input  logic                frame_ack,
  output logic [N_VOTERS-1:0] x,
  output logic                x_valid,
  output logic [2:0]          vote_idx,
  output logic                timeout_err,
  output logic                parity_err
);

  localparam int SW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
`ifdef BALLOT_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t              state_q;
  logic [N_VOTERS-1:0] sr_q, sr_shift, vb_msb;
  logic [N_VOTERS-1:0] x_q;
  logic                x_valid_q;
  logic [2:0]          vote_idx_q;
  logic [SW-1:0]       stall_q;
  logic                timeout_err_q;
  logic                accept, last, in_frame;

  assign vote_ready  = (state_q != HOLD);
  assign accept      = vote_valid & vote_ready;
  assign last        = (vote_idx_q == 3'(N_VOTERS - 1));
  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign vote_idx    = vote_idx_q;
  assign timeout_err = timeout_err_q;

  // Votes enter at the MSB and shift down, so after N shifts vote 0 sits at bit 0.
  always_comb begin
    vb_msb = '0;
    vb_msb[N_VOTERS-1] = vote_bit;
    sr_shift = (sr_q >> 1) | vb_msb;
  end

  always_comb begin
    in_frame = (state_q == COLLECT);
`ifdef BALLOT_PARITY_EN
    if (state_q == PARITY) in_frame = 1'b1;
`endif
  end

`ifdef BALLOT_PARITY_EN
  logic parity_err_q;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      x_q           <= '0;
      x_valid_q     <= 1'b0;
      vote_idx_q    <= '0;
      stall_q       <= '0;
      timeout_err_q <= 1'b0;
`ifdef BALLOT_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      timeout_err_q <= 1'b0;
`ifdef BALLOT_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
      if (in_frame && !accept) begin
        if (stall_q == SW'(TIMEOUT - 1)) begin
          state_q       <= IDLE;
          vote_idx_q    <= '0;
          stall_q       <= '0;
          timeout_err_q <= 1'b1;
        end else begin
          stall_q <= stall_q + SW'(1);
        end
      end else begin
        case (state_q)
          IDLE, COLLECT: begin
            if (accept) begin
              sr_q    <= sr_shift;
              stall_q <= '0;
              if (last) begin
`ifdef BALLOT_PARITY_EN
                vote_idx_q <= 3'(N_VOTERS);
                state_q    <= PARITY;
`else
                x_q        <= sr_shift;
                x_valid_q  <= 1'b1;
                vote_idx_q <= '0;
                state_q    <= HOLD;
`endif
              end else begin
                vote_idx_q <= vote_idx_q + 3'd1;
                state_q    <= COLLECT;
              end
            end
          end
`ifdef BALLOT_PARITY_EN
          PARITY: begin
            // Only reached with accept set; stalls are handled above.
            stall_q    <= '0;
            vote_idx_q <= '0;
            if (!(^sr_q ^ vote_bit)) begin
              x_q       <= sr_q;
              x_valid_q <= 1'b1;
              state_q   <= HOLD;
            end else begin
              parity_err_q <= 1'b1;
              state_q      <= IDLE;
            end
          end
`endif
          HOLD: begin
            if (frame_ack) begin
              x_valid_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ballot_collector.sv
// Directed bench for ballot_collector: reset, framing, hold/ack, timeout, stress, parity.
module tb_ballot_collector;
  localparam int N  = 7;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst, vote_valid, vote_bit, vote_ready, frame_ack;
  logic [N-1:0] x;
  logic         x_valid, timeout_err, parity_err;
  logic [2:0]   vote_idx;

  int n_cmp = 0, n_err = 0, tmo_cnt = 0, par_cnt = 0;

  ballot_collector #(.N_VOTERS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .vote_valid(vote_valid), .vote_bit(vote_bit),
    .vote_ready(vote_ready), .frame_ack(frame_ack), .x(x), .x_valid(x_valid),
    .vote_idx(vote_idx), .timeout_err(timeout_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (timeout_err) tmo_cnt++;
    if (parity_err) par_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      vote_valid = 1'b1;
      vote_bit   = b[i];
      tick();
    end
    vote_valid = 1'b0;
    vote_bit   = 1'b0;
  endtask

  // Sends vote 6 and, with parity enabled, the even-parity trailer.
  task automatic finish_frame(input logic [6:0] f);
    send_bits({7'b0, f[6]}, 1);
`ifdef BALLOT_PARITY_EN
    send_bits({7'b0, ^f}, 1);
`endif
  endtask

  task automatic send_frame(input logic [6:0] f);
    send_bits({1'b0, f}, 6);
    finish_frame(f);
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  initial begin
    logic [6:0] f;
    rst = 1'b1; vote_valid = 1'b0; vote_bit = 1'b0; frame_ack = 1'b0;
    tick(); tick();
    check("rst_x", x, 0);
    check("rst_xv", x_valid, 0);
    check("rst_idx", vote_idx, 0);
    check("rst_rdy", vote_ready, 1);
    check("rst_tmo", timeout_err, 0);
    check("rst_par", parity_err, 0);
    rst = 1'b0;
    tick();

    // Frame 1,0,1,1,0,0,1 back-to-back
    f = 7'b1001101;
    send_bits({1'b0, f}, 6);
    check("f_idx6", vote_idx, 6);
    check("f_xv_early", x_valid, 0);
    check("f_x_early", x, 0);
    finish_frame(f);
    check("f_xv", x_valid, 1);
    check("f_x", x, 7'b1001101);
    check("f_rdy", vote_ready, 0);
    check("f_idx", vote_idx, 0);
    check("f_pop", $countones(x), 4);

    // Hold, then ack colliding with a vote
    tick(); tick();
    check("hold_xv", x_valid, 1);
    check("hold_x", x, 7'b1001101);
    vote_valid = 1'b1; vote_bit = 1'b1; frame_ack = 1'b1;
    tick();
    vote_valid = 1'b0; vote_bit = 1'b0; frame_ack = 1'b0;
    check("ack_xv", x_valid, 0);
    check("ack_rdy", vote_ready, 1);
    check("ack_idx", vote_idx, 0);
    check("ack_xkeep", x, 7'b1001101);
    f = 7'b0110010;
    send_frame(f);
    check("nodup_x", x, 7'b0110010);
    ack();

    // Reset mid-frame after 3 votes
    send_bits(8'b0000_0111, 3);
    check("mid_idx3", vote_idx, 3);
    #2 rst = 1'b1;
    #1;
    check("mrst_x", x, 0);
    check("mrst_xv", x_valid, 0);
    check("mrst_idx", vote_idx, 0);
    check("mrst_rdy", vote_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    check("mrst_tmo_cnt", tmo_cnt, 0);

    // Timeout after 4 votes and 15 idle cycles
    send_bits(8'b0000_1011, 4);
    repeat (TO - 1) tick();
    check("to_early", timeout_err, 0);
    check("to_idx4", vote_idx, 4);
    tick();
    check("to_pulse", timeout_err, 1);
    check("to_idx0", vote_idx, 0);
    check("to_rdy", vote_ready, 1);
    tick();
    check("to_clear", timeout_err, 0);
    check("to_cnt1", tmo_cnt, 1);
    f = 7'b1110000;
    send_frame(f);
    check("fresh_x", x, 7'b1110000);
    check("fresh_xv", x_valid, 1);
    ack();

    // 14 idle cycles inside a frame are tolerated
    f = 7'b1010110;
    send_bits({1'b0, f}, 4);
    repeat (TO - 1) tick();
    check("to14_idx", vote_idx, 4);
    send_bits({1'b0, f} >> 4, 2);
    finish_frame(f);
    check("to14_x", x, 7'b1010110);
    check("to14_xv", x_valid, 1);
    check("to14_cnt", tmo_cnt, 1);
    ack();

    // Random gaps and ack delays; votes offered during HOLD must be ignored
    for (int fr = 0; fr < 200; fr++) begin
      f = 7'($urandom);
      check("st_idle", x_valid, 0);
      for (int i = 0; i < N; i++) begin
        repeat ($urandom_range(0, TO - 1)) tick();
        send_bits({7'b0, f[i]}, 1);
      end
`ifdef BALLOT_PARITY_EN
      repeat ($urandom_range(0, TO - 1)) tick();
      send_bits({7'b0, ^f}, 1);
`endif
      check("st_xv", x_valid, 1);
      check("st_x", x, {25'b0, f});
      vote_valid = 1'b1;
      vote_bit   = 1'($urandom);
      repeat ($urandom_range(0, 4)) tick();
      check("st_hold_x", x, {25'b0, f});
      ack();
      vote_valid = 1'b0;
      vote_bit   = 1'b0;
    end
    check("st_tmo_cnt", tmo_cnt, 1);

`ifdef BALLOT_PARITY_EN
    f = 7'b0000011;
    send_bits({1'b0, f}, 7);
    check("par_idx7", vote_idx, 7);
    check("par_xv_wait", x_valid, 0);
    send_bits(8'b0, 1);
    check("par_ok_xv", x_valid, 1);
    check("par_ok_x", x, 7'b0000011);
    ack();
    send_bits({1'b0, f}, 7);
    send_bits(8'b1, 1);
    check("par_bad_xv", x_valid, 0);
    check("par_bad_idx", vote_idx, 0);
    check("par_bad_x", x, 7'b0000011);
    tick();
    check("par_cnt", par_cnt, 1);
`else
    check("par_cnt", par_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
